// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the per-bundle control fields.
// Operand widths are parametrised per instance, so only width-independent fields live here.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ROL = 3'd0,
        OP_SLL = 3'd1,
        OP_ROR = 3'd2,
        OP_SRA = 3'd3,
        OP_ADD = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_AND = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic    cin;
        alu_op_t op;
        logic    sign;
    } s1_ctl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: shifter, adder, logic ops and flags on already-inverted operands.
// Zero latency; no handshake, it sits between the S1 and S2 registers.
module alu_core
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  alu_op_t          i_op,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout,
    output logic             o_ofl,
    output logic             o_zero
);

    localparam logic [SHAMT_W:0] W_FULL = (SHAMT_W + 1)'(WIDTH);

    logic [SHAMT_W-1:0] w_s;
    logic [SHAMT_W:0]   w_rs;
    logic [WIDTH-1:0]   w_rol;
    logic [WIDTH-1:0]   w_ror;
    logic [WIDTH-1:0]   w_sra;
    logic [WIDTH:0]     w_sum;
    logic               w_sofl;

    assign w_s = i_b[SHAMT_W-1:0];
    // Complementary shift is WIDTH when s == 0, which shifts everything out and leaves A intact.
    assign w_rs  = W_FULL - {1'b0, w_s};
    assign w_rol = (i_a << w_s) | (i_a >> w_rs);
    assign w_ror = (i_a >> w_s) | (i_a << w_rs);
    assign w_sra = $signed(i_a) >>> w_s;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};
    assign w_sofl = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        o_res  = '0;
        o_cout = 1'b0;
        o_ofl  = 1'b0;
        case (i_op)
            OP_ROL: o_res = w_rol;
            OP_SLL: o_res = i_a << w_s;
            OP_ROR: o_res = w_ror;
            OP_SRA: o_res = w_sra;
            OP_ADD: begin
                o_res  = w_sum[WIDTH-1:0];
                o_cout = w_sum[WIDTH];
                o_ofl  = i_sign ? w_sofl : w_sum[WIDTH];
            end
            OP_OR:  o_res = i_a | i_b;
            OP_XOR: o_res = i_a ^ i_b;
            OP_AND: o_res = i_a & i_b;
            default: o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers inverted operands, S2 registers result and flags; 2-cycle latency.
// Valid/ready on both sides; a stalled stage holds its contents and in_ready falls only when both stages are full.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    input  logic             inv_a,
    input  logic             inv_b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ofl,
    output logic             zero,
    output logic             ofl_sticky,
    input  logic             clr_flags
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        s1_ctl_t          ctl;
    } s1_t;

    s1_t              r_s1;
    logic             r_s1_v;
    logic             r_s2_v;
    logic [WIDTH-1:0] r_out;
    logic             r_cout;
    logic             r_ofl;
    logic             r_zero;
    logic             r_ofl_sticky;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ofl;
    logic             w_zero;

    assign w_s2_adv = !r_s2_v || out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_a    (r_s1.a),
        .i_b    (r_s1.b),
        .i_cin  (r_s1.ctl.cin),
        .i_op   (r_s1.ctl.op),
        .i_sign (r_s1.ctl.sign),
        .o_res  (w_res),
        .o_cout (w_cout),
        .o_ofl  (w_ofl),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1         <= '0;
            r_s1_v       <= 1'b0;
            r_s2_v       <= 1'b0;
            r_out        <= '0;
            r_cout       <= 1'b0;
            r_ofl        <= 1'b0;
            r_zero       <= 1'b1;
            r_ofl_sticky <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v       <= in_valid;
                r_s1.a       <= inv_a ? ~a : a;
                r_s1.b       <= inv_b ? ~b : b;
                r_s1.ctl.cin <= cin;
                r_s1.ctl.op  <= alu_op_t'(op);
                r_s1.ctl.sign <= sign;
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                r_out  <= w_res;
                r_cout <= w_cout;
                r_ofl  <= w_ofl;
                r_zero <= w_zero;
            end
            // A setting transfer takes priority over a simultaneous clear.
            if (r_s2_v && out_ready && r_ofl)
                r_ofl_sticky <= 1'b1;
            else if (clr_flags)
                r_ofl_sticky <= 1'b0;
        end
    end

    assign in_ready   = w_s1_adv;
    assign out_valid  = r_s2_v;
    assign out        = r_out;
    assign cout       = r_cout;
    assign ofl        = r_ofl;
    assign zero       = r_zero;
    assign ofl_sticky = r_ofl_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 16-bit instance for function/handshake/flags, 32-bit instance for width scaling.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        h_in_valid, h_in_ready, h_cin, h_inv_a, h_inv_b, h_sign;
    logic [15:0] h_a, h_b, h_out;
    logic [2:0]  h_op;
    logic        h_out_valid, h_out_ready, h_cout, h_ofl, h_zero, h_sticky, h_clr;

    // 32-bit instance
    logic        x_in_valid, x_in_ready, x_cin, x_inv_a, x_inv_b, x_sign;
    logic [31:0] x_a, x_b, x_out;
    logic [2:0]  x_op;
    logic        x_out_valid, x_out_ready, x_cout, x_ofl, x_zero, x_sticky, x_clr;

    int n_vec = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .cin(h_cin), .op(h_op), .inv_a(h_inv_a), .inv_b(h_inv_b),
        .sign(h_sign), .out_valid(h_out_valid), .out_ready(h_out_ready), .out(h_out),
        .cout(h_cout), .ofl(h_ofl), .zero(h_zero), .ofl_sticky(h_sticky), .clr_flags(h_clr)
    );

    alu_pipe #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .op(x_op), .inv_a(x_inv_a), .inv_b(x_inv_b),
        .sign(x_sign), .out_valid(x_out_valid), .out_ready(x_out_ready), .out(x_out),
        .cout(x_cout), .ofl(x_ofl), .zero(x_zero), .ofl_sticky(x_sticky), .clr_flags(x_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                           input logic c, input logic ia, input logic ib, input logic sg);
        h_in_valid = 1'b1;
        h_op = o; h_a = va; h_b = vb; h_cin = c; h_inv_a = ia; h_inv_b = ib; h_sign = sg;
    endtask

    // Transfer one bundle and advance until its result sits in S2.
    task automatic op16(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                        input logic c, input logic ia, input logic ib, input logic sg);
        drive16(o, va, vb, c, ia, ib, sg);
        tick();
        h_in_valid = 1'b0;
        tick();
    endtask

    task automatic op32(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic c);
        x_in_valid = 1'b1;
        x_op = o; x_a = va; x_b = vb; x_cin = c; x_inv_a = 1'b0; x_inv_b = 1'b0; x_sign = 1'b0;
        tick();
        x_in_valid = 1'b0;
        tick();
    endtask

    initial begin
        logic seen;
        h_in_valid = 0; h_a = 0; h_b = 0; h_cin = 0; h_op = 0; h_inv_a = 0; h_inv_b = 0;
        h_sign = 0; h_out_ready = 1; h_clr = 0;
        x_in_valid = 0; x_a = 0; x_b = 0; x_cin = 0; x_op = 0; x_inv_a = 0; x_inv_b = 0;
        x_sign = 0; x_out_ready = 1; x_clr = 0;
        tick();
        tick();
        rst = 0;

        chk("rst_out_valid", h_out_valid, 0);
        chk("rst_in_ready", h_in_ready, 1);
        chk("rst_out", h_out, 0);
        chk("rst_zero", h_zero, 1);
        chk("rst_cout", h_cout, 0);
        chk("rst_ofl", h_ofl, 0);
        chk("rst_sticky", h_sticky, 0);

        // ROL with latency check
        drive16(3'd0, 16'h00EA, 16'd4, 0, 0, 0, 0);
        tick();
        h_in_valid = 1'b0;
        chk("rol_lat1_valid", h_out_valid, 0);
        tick();
        chk("rol_lat2_valid", h_out_valid, 1);
        chk("rol_out", h_out, 16'h0EA0);
        chk("rol_zero", h_zero, 0);
        tick();
        chk("rol_drained", h_out_valid, 0);

        op16(3'd3, 16'hFA7B, 16'd4, 0, 0, 0, 0); chk("sra_out", h_out, 16'hFFA7); tick();
        op16(3'd1, 16'hFA7B, 16'd4, 0, 0, 0, 0); chk("sll_out", h_out, 16'hA7B0); tick();
        op16(3'd2, 16'hFA7B, 16'd4, 0, 0, 0, 0); chk("ror_out", h_out, 16'hBFA7); tick();
        op16(3'd0, 16'h1234, 16'h0010, 0, 0, 0, 0); chk("rol_s0", h_out, 16'h1234); tick();
        op16(3'd5, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0); chk("or_out", h_out, 16'hFFF0); tick();
        op16(3'd6, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0); chk("xor_out", h_out, 16'hFF00); tick();
        op16(3'd7, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0);
        chk("and_out", h_out, 16'h00F0);
        chk("and_cout", h_cout, 0);
        tick();
        op16(3'd7, 16'hF0F0, 16'h0FF0, 0, 1, 0, 0); chk("and_inva", h_out, 16'h0F00); tick();
        // A - B via inverted B and carry-in
        op16(3'd4, 16'd5, 16'd5, 1, 0, 1, 1);
        chk("sub_out", h_out, 0);
        chk("sub_zero", h_zero, 1);
        chk("sub_cout", h_cout, 1);
        chk("sub_ofl", h_ofl, 0);
        tick();

        // Signed overflow and sticky
        op16(3'd4, 16'h4E20, 16'h4E20, 0, 0, 0, 1);
        chk("sadd_out", h_out, 16'h9C40);
        chk("sadd_ofl", h_ofl, 1);
        chk("sadd_cout", h_cout, 0);
        tick();
        chk("sadd_sticky", h_sticky, 1);
        h_clr = 1; tick(); h_clr = 0;
        chk("clr_sticky", h_sticky, 0);

        op16(3'd4, 16'hEA60, 16'hEA60, 0, 0, 0, 0);
        chk("uadd_out", h_out, 16'hD4C0);
        chk("uadd_cout", h_cout, 1);
        chk("uadd_ofl", h_ofl, 1);
        tick();
        h_clr = 1; tick(); h_clr = 0;

        op16(3'd4, 16'hFFF6, 16'hB1E0, 0, 0, 0, 1);
        chk("sneg_out", h_out, 16'hB1D6);
        chk("sneg_ofl", h_ofl, 0);
        chk("sneg_cout", h_cout, 1);
        tick();
        chk("sneg_sticky", h_sticky, 0);

        // Clear coinciding with an overflowing output transfer
        op16(3'd4, 16'h4E20, 16'h4E20, 0, 0, 0, 1);
        h_clr = 1; tick(); h_clr = 0;
        chk("setwins_sticky", h_sticky, 1);
        h_clr = 1; tick(); h_clr = 0;

        // Backpressure
        h_out_ready = 0;
        drive16(3'd4, 16'd1, 16'd1, 0, 0, 0, 0);
        chk("bp_rdy1", h_in_ready, 1);
        tick();
        drive16(3'd4, 16'd2, 16'd2, 0, 0, 0, 0);
        chk("bp_rdy2", h_in_ready, 1);
        tick();
        drive16(3'd4, 16'd3, 16'd3, 0, 0, 0, 0);
        chk("bp_rdy3", h_in_ready, 0);
        tick();
        chk("bp_hold_rdy", h_in_ready, 0);
        chk("bp_hold_valid", h_out_valid, 1);
        chk("bp_hold_out", h_out, 16'h0002);
        h_out_ready = 1;
        #1;
        chk("bp_release_rdy", h_in_ready, 1);
        chk("bp_res1", h_out, 16'h0002);
        tick();
        h_in_valid = 0;
        chk("bp_res2_valid", h_out_valid, 1);
        chk("bp_res2", h_out, 16'h0004);
        tick();
        chk("bp_res3_valid", h_out_valid, 1);
        chk("bp_res3", h_out, 16'h0006);
        tick();
        chk("bp_empty", h_out_valid, 0);

        // Reset with both stages full
        h_out_ready = 0;
        drive16(3'd4, 16'd7, 16'd7, 0, 0, 0, 0);
        tick();
        drive16(3'd4, 16'd8, 16'd8, 0, 0, 0, 0);
        tick();
        h_in_valid = 0;
        chk("full_valid", h_out_valid, 1);
        chk("full_rdy", h_in_ready, 0);
        rst = 1; tick(); rst = 0;
        chk("mrst_valid", h_out_valid, 0);
        chk("mrst_rdy", h_in_ready, 1);
        chk("mrst_out", h_out, 0);
        chk("mrst_zero", h_zero, 1);
        h_out_ready = 1;
        seen = 0;
        repeat (4) begin
            tick();
            if (h_out_valid) seen = 1;
        end
        chk("mrst_no_stale", seen, 0);

        // 32-bit instance
        op32(3'd4, 32'hFFFF_FFFF, 32'd0, 1);
        chk("w32_add_out", x_out, 32'd0);
        chk("w32_add_zero", x_zero, 1);
        chk("w32_add_cout", x_cout, 1);
        tick();
        op32(3'd0, 32'h8000_0001, 32'd31, 0);
        chk("w32_rol_out", x_out, 32'hC000_0000);
        chk("w32_rol_zero", x_zero, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the 16-bit combinational ALU.
- Operation set and encoding are unchanged: rotate, shift, add, logic ops; operand inversion; signed/unsigned overflow; zero flag.
- Adds a WIDTH parameter, valid/ready handshakes with backpressure, carry-out, and a sticky overflow flag.
- Sits between the decode/operand-fetch stage and writeback in the pipelined datapath.

Parameters:
- WIDTH, 16, operand/result width; power of two, minimum 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  stage 1 can accept a bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; low SHAMT_W bits are the shift amount.
- cin  in  1  carry-in (ADD only).
- op  in  3  0 ROL, 1 SLL, 2 ROR, 3 SRA, 4 ADD, 5 OR, 6 XOR, 7 AND.
- inv_a, inv_b  in  1 each  invert the operand before use, for all ops.
- sign  in  1  1 = signed overflow rule, 0 = unsigned rule.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result.
- cout  out  1  carry out of MSB (ADD only, else 0).
- ofl  out  1  overflow for this result.
- zero  out  1  out == 0.
- ofl_sticky  out  1  set by any accepted overflowing result.
- clr_flags  in  1  clears ofl_sticky.

Behaviour:
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (S1):
  - Registers A' = inv_a ? ~a : a, B' = inv_b ? ~b : b, plus cin, op, sign.
  - Holds its own valid bit, s1_v.
- Stage 2 (S2):
  - Computes from the S1 registers and registers out, cout, ofl, zero.
  - Holds its own valid bit, s2_v; out_valid = s2_v.
- Latency: 2 cycles, input transfer edge to out_valid with no stall. Throughput: 1 result per cycle.
- Advance rules:
  - s2_adv = !s2_v || out_ready
  - s1_adv = !s1_v || s2_adv
  - in_ready = s1_adv, purely combinational from state and out_ready.
  - On s2_adv, S2 loads S1 contents and s2_v <= s1_v.
  - On s1_adv, S1 loads inputs and s1_v <= in_valid.
  - Stalled stages hold all contents bit-exact. No bundle is dropped or duplicated under any out_ready pattern.
- Arithmetic, with s = B'[SHAMT_W-1:0]:
  - ROL/ROR: rotate by s.
  - SLL: zero fill.
  - SRA: fill with A'[WIDTH-1].
  - Shift by s = 0 returns A'.
  - ADD: {cout, out} = A' + B' + cin, computed at WIDTH+1 bits.
  - Signed ofl = (A' MSB == B' MSB) && (out MSB != A' MSB).
  - Unsigned ofl = cout.
  - Non-ADD ops: cout = 0, ofl = 0.
  - zero is evaluated for every op.
- Sticky flag:
  - ofl_sticky sets on an output transfer with ofl = 1.
  - clr_flags clears it.
  - If a clear and a setting transfer occur in the same cycle, set wins.
- Reset:
  - s1_v, s2_v, out, cout, ofl, ofl_sticky go to 0; zero goes to 1 (out == 0).
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight bundles. The bench sees no out_valid until new input is transferred.
- With in_valid low, bubbles propagate; out_valid falls after the last result transfers.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ROL … OP_AND, as a 3-bit typedef alu_op_t.
  - S1 bundle struct: a, b, cin, op, sign.
- Sub-module alu_core:
  - Purely combinational, parametrised by WIDTH: shifter, adder, logic, flags.
  - Instantiated between S1 and S2.
- alu_pipe contains only the registers and handshake logic.

Test Plan:
- ROL, WIDTH=16, a=0x00EA, b=4, out_ready=1:
  - out=0x0EA0, zero=0.
  - out_valid exactly 2 cycles after transfer.
- SRA a=0xFA7B, b=4 -> out=0xFFA7. SLL same operands -> 0xA7B0. ROR same operands -> 0xBFA7.
- ADD overflow cases:
  - sign=1, a=b=20000 (0x4E20) -> out=0x9C40, ofl=1, ofl_sticky=1.
  - sign=0, a=b=60000 -> out=0xD4C0, cout=1, ofl=1.
  - sign=1, a=-10, b=-20000 -> ofl=0.
- Backpressure:
  - Issue 0x0001+0x0001, 0x0002+0x0002, 0x0003+0x0003 back-to-back with out_ready=0 -> in_ready drops after 2 accepted.
  - Release out_ready -> outputs 0x0002, 0x0004, 0x0006 in order; none lost.
- Flags and reset:
  - clr_flags asserted in the same cycle as an overflowing transfer -> ofl_sticky stays 1.
  - rst with both stages full -> out_valid=0 next cycle, no stale results later.
- Width generalisation, WIDTH=32:
  - ADD a=0xFFFFFFFF, b=0, cin=1 -> out=0, zero=1, cout=1.
  - ROL a=0x80000001, b=31 -> 0xC0000000.
